seq_barrel_shifter: RTL and testbench

//  Multi-cycle, parametrised shift unit for the processor ALU path. Accepts operand, shift

---
 rtl/shifter_pkg.sv | 24 ++
 rtl/shift_stage.sv | 58 +++++
 rtl/seq_barrel_shifter.sv | 122 ++++++++++++
 tb/tb_seq_barrel_shifter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the sequential barrel shifter: op encodings,
// FSM state encoding and a small width helper.
// Optional feature macro: SHIFTER_ROTATE_EN (enables op 11 = rotate right).
package shifter_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Bits needed to index n items, never less than one so ports stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One conditional power-of-two shift step. The distance 2^sel_i is picked
// from a small set of fixed-distance candidates, so no variable shifter is
// built. msb_i is the original operand MSB, used as the arithmetic fill.
// Optional feature macro: SHIFTER_ROTATE_EN (adds the rotate-right candidate).
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int IDX_W   = idx_width(SHAMT_W)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       op_i,
    input  logic             msb_i,
    input  logic             en_i,
    input  logic [IDX_W-1:0] sel_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] cand_w [SHAMT_W];

    genvar gi;
    generate
        for (gi = 0; gi < SHAMT_W; gi++) begin : g_dist
            localparam int DIST = 1 << gi;
            logic [WIDTH-1:0] sll_w;
            logic [WIDTH-1:0] srl_w;
            logic [WIDTH-1:0] sra_w;
            assign sll_w = data_i << DIST;
            assign srl_w = data_i >> DIST;
            assign sra_w = srl_w | ({WIDTH{msb_i}} << (WIDTH - DIST));
`ifdef SHIFTER_ROTATE_EN
            logic [WIDTH-1:0] ror_w;
            assign ror_w = srl_w | (data_i << (WIDTH - DIST));
            assign cand_w[gi] = (op_i == OP_SLL) ? sll_w :
                                (op_i == OP_SRA) ? sra_w :
                                (op_i == OP_ROR) ? ror_w : srl_w;
`else
            // Without rotate support op 11 behaves as a logical right shift.
            assign cand_w[gi] = (op_i == OP_SLL) ? sll_w :
                                (op_i == OP_SRA) ? sra_w : srl_w;
`endif
        end
    endgenerate

    // Pass data through unless this shamt bit is set, then pick the distance.
    always_comb begin
        data_o = data_i;
        if (en_i) begin
            for (int j = 0; j < SHAMT_W; j++) begin
                if (sel_i == j[IDX_W-1:0]) begin
                    data_o = cand_w[j];
                end
            end
        end
    end

endmodule

// File: rtl/seq_barrel_shifter.sv
// Multi-cycle shift unit. A request is latched on the valid/ready handshake,
// then STAGES_PER_CYCLE shamt bits are consumed per cycle (LSB first) for
// NCYC cycles; the result is held in DONE until the consumer takes it.
// A new request may be accepted in the same cycle the result is taken.
// Optional feature macro: SHIFTER_ROTATE_EN (op 11 = rotate right, else SRL).
module seq_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int STAGES_PER_CYCLE = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     busy
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int NCYC    = SHAMT_W / STAGES_PER_CYCLE;
    localparam int CNT_W   = idx_width(NCYC);
    localparam int IDX_W   = idx_width(SHAMT_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NCYC - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [1:0]         op_q, op_d;
    logic               msb_q, msb_d;
    logic [CNT_W-1:0]   step_q, step_d;

    logic               accept_w;
    logic [WIDTH-1:0]   chain_w [STAGES_PER_CYCLE+1];

    assign chain_w[0] = data_q;

    // Stage gi of this cycle handles shamt bit step*STAGES_PER_CYCLE + gi.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES_PER_CYCLE; gi++) begin : g_stage
            logic [IDX_W-1:0] sel_w;
            assign sel_w = IDX_W'(int'(step_q) * STAGES_PER_CYCLE + gi);

            shift_stage #(
                .WIDTH   (WIDTH),
                .SHAMT_W (SHAMT_W),
                .IDX_W   (IDX_W)
            ) u_stage (
                .data_i (chain_w[gi]),
                .op_i   (op_q),
                .msb_i  (msb_q),
                .en_i   (shamt_q[sel_w]),
                .sel_i  (sel_w),
                .data_o (chain_w[gi+1])
            );
        end
    endgenerate

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept_w  = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_SHIFT);
    assign out_data  = data_q;

    // Next-state logic: accept, step through the shift stages, present result.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        op_d    = op_q;
        msb_d   = msb_q;
        step_d  = step_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_w) begin
                    state_d = ST_SHIFT;
                    data_d  = in_data;
                    shamt_d = in_shamt;
                    op_d    = in_op;
                    msb_d   = in_data[WIDTH-1];
                    step_d  = '0;
                end else if (state_q == ST_DONE && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                data_d = chain_w[STAGES_PER_CYCLE];
                step_d = step_q + 1'b1;
                if (step_q == LAST_STEP) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            shamt_q <= '0;
            op_q    <= '0;
            msb_q   <= 1'b0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            op_q    <= op_d;
            msb_q   <= msb_d;
            step_q  <= step_d;
        end
    end

endmodule

// File: tb/tb_seq_barrel_shifter.sv
// Directed bench for seq_barrel_shifter: unit A uses one stage per cycle
// (latency 5), unit B five stages per cycle (latency 1).
// Expected op-11 result depends on SHIFTER_ROTATE_EN.
module tb_seq_barrel_shifter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_busy;
    logic [1:0]  a_in_op = 2'b00;
    logic [31:0] a_in_data = '0, a_out_data;
    logic [4:0]  a_in_shamt = '0;

    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_busy;
    logic [1:0]  b_in_op = 2'b00;
    logic [31:0] b_in_data = '0, b_out_data;
    logic [4:0]  b_in_shamt = '0;

    int tests  = 0;
    int failed = 0;

    always #5 clock = ~clock;

    seq_barrel_shifter #(.WIDTH(32), .STAGES_PER_CYCLE(1)) dut_a (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_op     (a_in_op),
        .in_data   (a_in_data),
        .in_shamt  (a_in_shamt),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .busy      (a_busy)
    );

    seq_barrel_shifter #(.WIDTH(32), .STAGES_PER_CYCLE(5)) dut_b (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_op     (b_in_op),
        .in_data   (b_in_data),
        .in_shamt  (b_in_shamt),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .busy      (b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one request on unit 0 (A) or 1 (B), check latency, result, release.
    task automatic run_op(input int unit, input logic [1:0] op, input logic [31:0] data,
                          input logic [4:0] shamt, input logic [31:0] exp,
                          input int exp_lat, input string tag);
        int cyc;
        int wcyc;
        if (unit == 0) begin
            a_in_op = op; a_in_data = data; a_in_shamt = shamt; a_in_valid = 1'b1;
        end else begin
            b_in_op = op; b_in_data = data; b_in_shamt = shamt; b_in_valid = 1'b1;
        end
        #1;
        wcyc = 0;
        while (((unit == 0) ? a_in_ready : b_in_ready) == 1'b0 && wcyc < 20) begin
            tick();
            wcyc++;
        end
        tick();
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        cyc = 0;
        while (((unit == 0) ? a_out_valid : b_out_valid) == 1'b0 && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_data"}, (unit == 0) ? a_out_data : b_out_data, exp);
        if (unit == 0) a_out_ready = 1'b1; else b_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        b_out_ready = 1'b0;
        check({tag, "_taken"}, {31'd0, (unit == 0) ? a_out_valid : b_out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] ror_exp;
        logic        seen;
        int          cyc;

`ifdef SHIFTER_ROTATE_EN
        ror_exp = 32'h8000_0000;
`else
        ror_exp = 32'h0000_0000;
`endif

        // Reset state
        tick();
        tick();
        check("rst_a_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_a_out_data",  a_out_data,           32'd0);
        check("rst_a_busy",      {31'd0, a_busy},      32'd0);
        check("rst_a_in_ready",  {31'd0, a_in_ready},  32'd1);
        check("rst_b_out_valid", {31'd0, b_out_valid}, 32'd0);
        reset = 1'b0;
        tick();

        // Unit A: one stage per cycle
        run_op(0, 2'b10, 32'h8000_0000, 5'd2,  32'hE000_0000, 5, "a_sra_neg2");
        run_op(0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 5, "a_sll_31");
        run_op(0, 2'b01, 32'hF000_0000, 5'd4,  32'h0F00_0000, 5, "a_srl_4");
        run_op(0, 2'b10, 32'h1234_5678, 5'd0,  32'h1234_5678, 5, "a_shamt0");
        run_op(0, 2'b10, 32'h7FFF_0000, 5'd16, 32'h0000_7FFF, 5, "a_sra_pos16");
        run_op(0, 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 5, "a_sra_31");
        run_op(0, 2'b00, 32'hDEAD_BEEF, 5'd4,  32'hEADB_EEF0, 5, "a_sll_4");
        run_op(0, 2'b11, 32'h0000_0001, 5'd1,  ror_exp,       5, "a_op11");

        // Unit B: five stages per cycle
        run_op(1, 2'b10, 32'hFFFF_0000, 5'd8,  32'hFFFF_FF00, 1, "b_sra_8");
        run_op(1, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 1, "b_sll_31");
        run_op(1, 2'b01, 32'h8000_0000, 5'd17, 32'h0000_4000, 1, "b_srl_17");
        run_op(1, 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1, "b_sra_31");
        run_op(1, 2'b11, 32'h0000_0001, 5'd1,  ror_exp,       1, "b_op11");

        // Back-pressure hold, then back-to-back accept
        a_in_op = 2'b01; a_in_data = 32'h0000_FF00; a_in_shamt = 5'd8; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        cyc = 0;
        while (!a_out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("hold_lat", cyc, 32'd5);
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_in_op    = 2'b00;
            a_in_data  = 32'h0BAD_0000 + i;
            a_in_shamt = 5'(i + 3);
            tick();
            check("hold_data",     a_out_data,            32'h0000_00FF);
            check("hold_valid",    {31'd0, a_out_valid},  32'd1);
            check("hold_in_ready", {31'd0, a_in_ready},   32'd0);
        end
        a_in_op = 2'b00; a_in_data = 32'h0000_0003; a_in_shamt = 5'd1;
        a_in_valid = 1'b1; a_out_ready = 1'b1;
        #1;
        check("b2b_in_ready", {31'd0, a_in_ready}, 32'd1);
        tick();
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        check("b2b_busy",  {31'd0, a_busy},      32'd1);
        check("b2b_valid", {31'd0, a_out_valid}, 32'd0);
        cyc = 0;
        while (!a_out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("b2b_lat",  cyc,        32'd5);
        check("b2b_data", a_out_data, 32'h0000_0006);
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;

        // Reset during the second SHIFT cycle discards the operation
        a_in_op = 2'b00; a_in_data = 32'h0000_0001; a_in_shamt = 5'd3; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        tick();
        check("mid_busy_before", {31'd0, a_busy}, 32'd1);
        reset = 1'b1;
        tick();
        check("mid_rst_valid",    {31'd0, a_out_valid}, 32'd0);
        check("mid_rst_busy",     {31'd0, a_busy},      32'd0);
        check("mid_rst_in_ready", {31'd0, a_in_ready},  32'd1);
        check("mid_rst_data",     a_out_data,           32'd0);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | a_out_valid;
        end
        check("mid_rst_no_stale", {31'd0, seen}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
